multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the MIPS-lite datapath. Sequences fetch/decode/execute/memory/writeback and drives every select of the register-destination, ALU-B and result muxes, plus all write strobes, ALU op and next-PC select. Sits beside the datapath, consuming the latched IR and the ALU zero flag. Stalls on ready handshakes from instruction and data memory.

## Interface
Parameters:
- `RA_IDX`, 31: register index forced by `raWrite` (informational; the mux hard-wires it).

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `ir`  in  32  instruction register contents; valid from DECODE onward
- `zero`  in  1  ALU zero flag; sampled in EXEC
- `imem_ready`  in  1  instruction word available this cycle
- `dmem_ready`  in  1  data access completes this cycle
- `IRWrite`  out  1  load IR
- `PCWrite`  out  1  load PC from NPC
- `NPCSel`  out  2  0=PC+4, 1=branch target, 2=jump target, 3=register (jr)
- `RegWrite`  out  1  GRF write enable
- `RegDst`  out  1  0=rt, 1=rd
- `raWrite`  out  1  write register 31
- `ALUSrc`  out  1  0=RD2, 1=extended immediate
- `ExtOp`  out  2  0=zero-ext, 1=sign-ext, 2=lui (imm<<16)
- `ALUOp`  out  3  0=add, 1=sub, 2=or, 3=pass-B
- `MemRead`  out  1  data memory read request
- `MemWrite`  out  1  data memory write request
- `MemtoReg`  out  1  result = memory data
- `PCtoReg`  out  1  result = PC+4 (overrides MemtoReg)
- `retire`  out  1  one-cycle pulse when an instruction completes

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH: wait while `imem_ready`=0. When it is 1, assert `IRWrite`, `PCWrite` with `NPCSel`=0, and go to DECODE.
- DECODE: classify `ir[31:26]`/`ir[5:0]`: R-type addu (100001), subu (100011), jr (001000); ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011. Go to EXEC. An unknown encoding pulses `retire`, returns to FETCH, and writes nothing.
- EXEC actions:
  - addu/subu/ori/lui/lw/sw: ALU computes (lw/sw add, `ALUSrc`=1, `ExtOp`=1; ori `ExtOp`=0, `ALUOp`=2; lui `ExtOp`=2, `ALUOp`=3). Then addu/subu/ori/lui go to WB and lw/sw go to MEM.
  - beq: `ALUOp`=1. If `zero`, assert `PCWrite` with `NPCSel`=1. Pulse `retire` and go to FETCH.
  - j: `PCWrite`, `NPCSel`=2; retire.
  - jal: same as j, plus `RegWrite`, `raWrite`, `PCtoReg` (PC+4 of the jal itself); retire.
  - jr: `PCWrite`, `NPCSel`=3; retire.
- MEM: hold `MemRead` (lw) or `MemWrite` (sw) until `dmem_ready`=1.
  - sw then retires and goes to FETCH.
  - lw goes to WB.
- WB: assert `RegWrite`. R-type uses `RegDst`=1; ori/lui/lw use `RegDst`=0. lw also asserts `MemtoReg`. Pulse `retire` and go to FETCH.
- Outputs are Moore-decoded from state and `ir`. Exceptions: the FETCH strobes qualify on `imem_ready`, the EXEC beq `PCWrite` qualifies on `zero`, and the MEM exit qualifies on `dmem_ready`.
- Selects not listed for a state are 0. Strobes are never asserted outside the listed cycles.

## Timing
- Reset (`reset`=0, asynchronous) forces state to FETCH and all outputs to 0, even if `imem_ready`=1. Outputs stay 0 until the first rising edge after deassertion.
- Reset mid-instruction aborts it with no partial write; a MEM-state request drops immediately.
- Latency with zero wait: beq/j/jal/jr = 3 cycles; addu/subu/ori/lui/sw = 4; lw = 5; unknown = 2. Each wait cycle adds 1.
- `retire` is high exactly in the final cycle of each instruction, and the next cycle is FETCH.
- `ir` must be stable from DECODE until retire. The controller never asserts `IRWrite` outside FETCH.
- `MemRead`/`MemWrite` stay high and constant across all wait cycles. There is exactly one accepted access per lw/sw.

## Structure
- Package `ctrl_pkg`: state enum, opcode/funct constants, `ALUOp`/`ExtOp`/`NPCSel` encodings.
- Sub-module `instr_class_dec`: combinational decode of `ir` into one-hot instruction class. The FSM consumes only the class.
- FSM: one state register plus combinational output decode. No other storage.

## Test plan
- Reset asserted mid-MEM of sw with `dmem_ready`=0: `MemWrite` drops to 0 immediately; after release, state is FETCH and `IRWrite` rises only with `imem_ready`.
- addu $3,$1,$2 (0x00221821), ready always 1: `retire` on cycle 4; WB has `RegWrite`=1, `RegDst`=1, `MemtoReg`=0.
- lw $5,4($0) (0x8C050004) with `dmem_ready` low for 2 cycles: `MemRead` high for 3 cycles; `retire` on cycle 7; WB has `MemtoReg`=1, `RegDst`=0.
- beq (0x10220003): with `zero`=1, cycle 3 has `PCWrite`=1, `NPCSel`=1; with `zero`=0, `PCWrite`=0; `retire` on cycle 3 in both cases.
- jal (0x0C000010): cycle 3 has `PCWrite`=1, `NPCSel`=2, `RegWrite`=1, `raWrite`=1, `PCtoReg`=1.
- `imem_ready` held low for 5 cycles, then opcode 0x3F: no `IRWrite` during the 5 cycles; then DECODE pulses `retire` with no `RegWrite` or `MemWrite`.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the MIPS-lite multi-cycle controller:
// FSM states, opcode/funct constants, mux select encodings and the control word.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_PASSB = 3'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_REG    = 2'd3;

  // One-hot instruction class; all-zero means an unknown encoding.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
  } iclass_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] npc_sel;
    logic       reg_write;
    logic       reg_dst;
    logic       ra_write;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       retire;
  } ctrl_out_t;

  function automatic logic is_rtype_alu(input iclass_t c);
    return c.addu | c.subu;
  endfunction

  function automatic logic is_mem_access(input iclass_t c);
    return c.lw | c.sw;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: latched IR, status and handshakes in,
// mux selects and write strobes out.
interface multicycle_ctrl_if;

  logic [31:0] ir;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        IRWrite;
  logic        PCWrite;
  logic [1:0]  NPCSel;
  logic        RegWrite;
  logic        RegDst;
  logic        raWrite;
  logic        ALUSrc;
  logic [1:0]  ExtOp;
  logic [2:0]  ALUOp;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        PCtoReg;
  logic        retire;

  modport master (
    input  ir, zero, imem_ready, dmem_ready,
    output IRWrite, PCWrite, NPCSel, RegWrite, RegDst, raWrite, ALUSrc,
           ExtOp, ALUOp, MemRead, MemWrite, MemtoReg, PCtoReg, retire
  );

  modport slave (
    output ir, zero, imem_ready, dmem_ready,
    input  IRWrite, PCWrite, NPCSel, RegWrite, RegDst, raWrite, ALUSrc,
           ExtOp, ALUOp, MemRead, MemWrite, MemtoReg, PCtoReg, retire
  );

endinterface

// File: rtl/multicycle_ctrl_dec.sv
// Combinational classification of the latched instruction word into a one-hot
// class; only opcode and funct fields matter.
module instr_class_dec
  import ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_t     cls,
  output logic        cls_valid
);

  logic [5:0] op_s;
  logic [5:0] fn_s;
  logic       unused_ir_s;

  assign op_s        = ir[31:26];
  assign fn_s        = ir[5:0];
  assign unused_ir_s = ^ir[25:6];

  // Opcode/funct lookup; anything unlisted leaves every class bit clear.
  always_comb begin
    cls = '0;
    case (op_s)
      OP_RTYPE: begin
        case (fn_s)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: cls      = '0;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls     = '0;
    endcase
  end

  assign cls_valid = |cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-lite datapath.
// Control outputs are decoded from state and instruction class.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int RA_IDX = 31
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  // The link register index is fixed in the datapath mux; raWrite only means r31.
  localparam logic RA_HARDWIRED = (RA_IDX == 32'sd31);

  state_t    state_q, state_d;
  logic      run_q;
  iclass_t   cls_s;
  logic      cls_valid_s;
  ctrl_out_t out_s;
  ctrl_out_t out_g_s;

  instr_class_dec u_dec (
    .ir        (bus.ir),
    .cls       (cls_s),
    .cls_valid (cls_valid_s)
  );

  // Next-state and Moore control decode.
  always_comb begin
    out_s   = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ready) begin
          out_s.ir_write = 1'b1;
          out_s.pc_write = 1'b1;
          out_s.npc_sel  = NPC_PC4;
          state_d        = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (cls_valid_s) begin
          state_d = S_EXEC;
        end else begin
          out_s.retire = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_rtype_alu(cls_s)) begin
          out_s.alu_op = cls_s.subu ? ALU_SUB : ALU_ADD;
          state_d      = S_WB;
        end else if (cls_s.ori) begin
          out_s.alu_src = 1'b1;
          out_s.ext_op  = EXT_ZERO;
          out_s.alu_op  = ALU_OR;
          state_d       = S_WB;
        end else if (cls_s.lui) begin
          out_s.alu_src = 1'b1;
          out_s.ext_op  = EXT_LUI;
          out_s.alu_op  = ALU_PASSB;
          state_d       = S_WB;
        end else if (is_mem_access(cls_s)) begin
          out_s.alu_src = 1'b1;
          out_s.ext_op  = EXT_SIGN;
          out_s.alu_op  = ALU_ADD;
          state_d       = S_MEM;
        end else if (cls_s.beq) begin
          out_s.alu_op   = ALU_SUB;
          out_s.pc_write = bus.zero;
          out_s.npc_sel  = bus.zero ? NPC_BRANCH : NPC_PC4;
          out_s.retire   = 1'b1;
          state_d        = S_FETCH;
        end else if (cls_s.j | cls_s.jal) begin
          // jal links PC+4 of itself, which the datapath already holds in PC.
          out_s.pc_write  = 1'b1;
          out_s.npc_sel   = NPC_JUMP;
          out_s.reg_write = cls_s.jal;
          out_s.ra_write  = cls_s.jal & RA_HARDWIRED;
          out_s.pc_to_reg = cls_s.jal;
          out_s.retire    = 1'b1;
          state_d         = S_FETCH;
        end else if (cls_s.jr) begin
          out_s.pc_write = 1'b1;
          out_s.npc_sel  = NPC_REG;
          out_s.retire   = 1'b1;
          state_d        = S_FETCH;
        end else begin
          out_s.retire = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_MEM: begin
        out_s.mem_read  = cls_s.lw;
        out_s.mem_write = cls_s.sw;
        if (bus.dmem_ready || !is_mem_access(cls_s)) begin
          if (cls_s.lw) begin
            state_d = S_WB;
          end else begin
            out_s.retire = 1'b1;
            state_d      = S_FETCH;
          end
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        out_s.reg_write  = 1'b1;
        out_s.reg_dst    = is_rtype_alu(cls_s);
        out_s.mem_to_reg = cls_s.lw;
        out_s.retire     = 1'b1;
        state_d          = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // run_q keeps the controller parked and silent until the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= run_q ? state_d : S_FETCH;
    end
  end

  assign out_g_s = run_q ? out_s : '0;

  assign bus.IRWrite  = out_g_s.ir_write;
  assign bus.PCWrite  = out_g_s.pc_write;
  assign bus.NPCSel   = out_g_s.npc_sel;
  assign bus.RegWrite = out_g_s.reg_write;
  assign bus.RegDst   = out_g_s.reg_dst;
  assign bus.raWrite  = out_g_s.ra_write;
  assign bus.ALUSrc   = out_g_s.alu_src;
  assign bus.ExtOp    = out_g_s.ext_op;
  assign bus.ALUOp    = out_g_s.alu_op;
  assign bus.MemRead  = out_g_s.mem_read;
  assign bus.MemWrite = out_g_s.mem_write;
  assign bus.MemtoReg = out_g_s.mem_to_reg;
  assign bus.PCtoReg  = out_g_s.pc_to_reg;
  assign bus.retire   = out_g_s.retire;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control words compared against
// hand-derived vectors for each instruction class, reset and stall cases.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       irw;
    logic       pcw;
    logic [1:0] npc;
    logic       regw;
    logic       regdst;
    logic       raw;
    logic       alusrc;
    logic [1:0] ext;
    logic [2:0] alu;
    logic       mrd;
    logic       mwr;
    logic       m2r;
    logic       pc2r;
    logic       ret;
  } obs_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  obs_t cur;
  obs_t trace [1:15];
  obs_t exp_v [1:15];
  int   nret;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.RA_IDX(31)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign cur = {bus.IRWrite, bus.PCWrite, bus.NPCSel, bus.RegWrite, bus.RegDst,
                bus.raWrite, bus.ALUSrc, bus.ExtOp, bus.ALUOp, bus.MemRead,
                bus.MemWrite, bus.MemtoReg, bus.PCtoReg, bus.retire};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: irw pcw npc regw regdst raw alusrc ext alu mrd mwr m2r pc2r ret
  function automatic obs_t mk(input int irw, input int pcw, input int npc, input int regw,
                              input int regdst, input int raw, input int alusrc,
                              input int ext, input int alu, input int mrd, input int mwr,
                              input int m2r, input int pc2r, input int ret);
    obs_t o;
    o.irw = irw[0];       o.pcw = pcw[0];       o.npc = npc[1:0];
    o.regw = regw[0];     o.regdst = regdst[0]; o.raw = raw[0];
    o.alusrc = alusrc[0]; o.ext = ext[1:0];     o.alu = alu[2:0];
    o.mrd = mrd[0];       o.mwr = mwr[0];       o.m2r = m2r[0];
    o.pc2r = pc2r[0];     o.ret = ret[0];
    return o;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.zero = 1'b0;
    bus.ir = 32'h0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
  endtask

  // Runs one instruction from FETCH; dmem_ready rises dwait cycles into MEM (cycle 4).
  task automatic run_instr(input logic [31:0] instr, input int dwait, input logic z);
    nret = 0;
    for (int c = 1; c <= 15; c++) trace[c] = '1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      bus.ir = instr;
      bus.imem_ready = 1'b1;
      bus.zero = z;
      bus.dmem_ready = (c >= 4 + dwait);
      #1;
      trace[c] = cur;
      if (cur.ret) begin
        nret = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    bus.zero = 1'b0;
    bus.ir = 32'h0;
    #3;
    tests_run++;
    if (cur !== '0) begin tests_failed++; $display("FAIL reset_hold: got %h want %h", cur, 18'h0); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (cur !== '0) begin tests_failed++; $display("FAIL reset_release_pre_edge: got %h want %h", cur, 18'h0); end
    @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (cur !== mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
      tests_failed++; $display("FAIL reset_first_fetch: got %h want %h", cur, mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.ir = 32'hAC050004;
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b0;
    end
    #1;
    tests_run++;
    if (cur !== mk(0,0,0,0,0,0,0,0,0,0,1,0,0,0)) begin
      tests_failed++; $display("FAIL midmem_memwrite: got %h want %h", cur, mk(0,0,0,0,0,0,0,0,0,0,1,0,0,0));
    end
    #1;
    reset = 1'b0;
    #1;
    tests_run++;
    if (cur !== '0) begin tests_failed++; $display("FAIL midmem_async_drop: got %h want %h", cur, 18'h0); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.imem_ready = 1'b0;
    #1;
    tests_run++;
    if (cur !== '0) begin tests_failed++; $display("FAIL midmem_released: got %h want %h", cur, 18'h0); end
    @(negedge clk);
    #1;
    tests_run++;
    if (cur !== '0) begin tests_failed++; $display("FAIL midmem_fetch_wait: got %h want %h", cur, 18'h0); end
    @(negedge clk);
    bus.imem_ready = 1'b1;
    #1;
    tests_run++;
    if (cur !== mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
      tests_failed++; $display("FAIL midmem_fetch_go: got %h want %h", cur, mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_addu();
    do_reset();
    run_instr(32'h00221821, 0, 1'b0);
    exp_v[1] = mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0);
    exp_v[2] = '0;
    exp_v[3] = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    exp_v[4] = mk(0,0,0,1,1,0,0,0,0,0,0,0,0,1);
    tests_run++;
    if (nret !== 4) begin tests_failed++; $display("FAIL addu_latency: got %0d want %0d", nret, 4); end
    for (int c = 1; c <= 4; c++) begin
      tests_run++;
      if (trace[c] !== exp_v[c]) begin
        tests_failed++; $display("FAIL addu_cycle%0d: got %h want %h", c, trace[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_lw_wait();
    do_reset();
    run_instr(32'h8C050004, 2, 1'b0);
    exp_v[1] = mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0);
    exp_v[2] = '0;
    exp_v[3] = mk(0,0,0,0,0,0,1,1,0,0,0,0,0,0);
    exp_v[4] = mk(0,0,0,0,0,0,0,0,0,1,0,0,0,0);
    exp_v[5] = exp_v[4];
    exp_v[6] = exp_v[4];
    exp_v[7] = mk(0,0,0,1,0,0,0,0,0,0,0,1,0,1);
    tests_run++;
    if (nret !== 7) begin tests_failed++; $display("FAIL lw_latency: got %0d want %0d", nret, 7); end
    for (int c = 1; c <= 7; c++) begin
      tests_run++;
      if (trace[c] !== exp_v[c]) begin
        tests_failed++; $display("FAIL lw_cycle%0d: got %h want %h", c, trace[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_beq();
    for (int zz = 1; zz >= 0; zz--) begin
      do_reset();
      run_instr(32'h10220003, 0, zz[0]);
      exp_v[1] = mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0);
      exp_v[2] = '0;
      exp_v[3] = mk(0,zz,zz,0,0,0,0,0,1,0,0,0,0,1);
      tests_run++;
      if (nret !== 3) begin tests_failed++; $display("FAIL beq_z%0d_latency: got %0d want %0d", zz, nret, 3); end
      for (int c = 1; c <= 3; c++) begin
        tests_run++;
        if (trace[c] !== exp_v[c]) begin
          tests_failed++; $display("FAIL beq_z%0d_cycle%0d: got %h want %h", zz, c, trace[c], exp_v[c]);
        end
      end
    end
  endtask

  task automatic test_jal();
    do_reset();
    run_instr(32'h0C000010, 0, 1'b0);
    exp_v[3] = mk(0,1,2,1,0,1,0,0,0,0,0,0,1,1);
    tests_run++;
    if (nret !== 3) begin tests_failed++; $display("FAIL jal_latency: got %0d want %0d", nret, 3); end
    tests_run++;
    if (trace[2] !== '0) begin tests_failed++; $display("FAIL jal_decode: got %h want %h", trace[2], 18'h0); end
    tests_run++;
    if (trace[3] !== exp_v[3]) begin tests_failed++; $display("FAIL jal_exec: got %h want %h", trace[3], exp_v[3]); end
  endtask

  // Back-to-back instructions with no reset in between: subu, ori, lui, sw, j, jr.
  task automatic test_back_to_back();
    logic [31:0] instrs [0:5];
    int          lat    [0:5];
    obs_t        ex     [0:5];
    obs_t        last   [0:5];
    instrs[0] = 32'h00221823; lat[0] = 4; ex[0] = mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0); last[0] = mk(0,0,0,1,1,0,0,0,0,0,0,0,0,1);
    instrs[1] = 32'h34220005; lat[1] = 4; ex[1] = mk(0,0,0,0,0,0,1,0,2,0,0,0,0,0); last[1] = mk(0,0,0,1,0,0,0,0,0,0,0,0,0,1);
    instrs[2] = 32'h3C011234; lat[2] = 4; ex[2] = mk(0,0,0,0,0,0,1,2,3,0,0,0,0,0); last[2] = mk(0,0,0,1,0,0,0,0,0,0,0,0,0,1);
    instrs[3] = 32'hAC050004; lat[3] = 4; ex[3] = mk(0,0,0,0,0,0,1,1,0,0,0,0,0,0); last[3] = mk(0,0,0,0,0,0,0,0,0,0,1,0,0,1);
    instrs[4] = 32'h08000010; lat[4] = 3; ex[4] = mk(0,1,2,0,0,0,0,0,0,0,0,0,0,1); last[4] = ex[4];
    instrs[5] = 32'h03E00008; lat[5] = 3; ex[5] = mk(0,1,3,0,0,0,0,0,0,0,0,0,0,1); last[5] = ex[5];
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      run_instr(instrs[k], 0, 1'b0);
      tests_run++;
      if (nret !== lat[k]) begin tests_failed++; $display("FAIL b2b%0d_latency: got %0d want %0d", k, nret, lat[k]); end
      tests_run++;
      if (trace[3] !== ex[k]) begin tests_failed++; $display("FAIL b2b%0d_exec: got %h want %h", k, trace[3], ex[k]); end
      tests_run++;
      if (trace[lat[k]] !== last[k]) begin
        tests_failed++; $display("FAIL b2b%0d_last: got %h want %h", k, trace[lat[k]], last[k]);
      end
    end
  endtask

  task automatic test_imem_wait_unknown();
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.ir = 32'hFC000000;
      bus.imem_ready = 1'b0;
      #1;
      tests_run++;
      if (cur !== '0) begin tests_failed++; $display("FAIL imem_wait%0d: got %h want %h", c, cur, 18'h0); end
    end
    @(negedge clk);
    bus.imem_ready = 1'b1;
    #1;
    tests_run++;
    if (cur !== mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
      tests_failed++; $display("FAIL imem_fetch: got %h want %h", cur, mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
    end
    @(negedge clk);
    bus.imem_ready = 1'b0;
    #1;
    tests_run++;
    if (cur !== mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1)) begin
      tests_failed++; $display("FAIL unknown_retire: got %h want %h", cur, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    end
    @(negedge clk);
    bus.imem_ready = 1'b1;
    #1;
    tests_run++;
    if (cur !== mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
      tests_failed++; $display("FAIL unknown_back_to_fetch: got %h want %h", cur, mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_reset_mid_mem();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal();
    test_back_to_back();
    test_imem_wait_unknown();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
